hsid_x_result_wb: RTL

HSID_X_RESULT_WB -- requirements
Module: hsid_x_result_wb

---
 rtl/hsid_x_obi_inf_pkg.sv | 18 +
 rtl/hsid_x_result_wb.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/hsid_x_obi_inf_pkg.sv
// OBI request/response types shared by the HSID-X bus masters.
package hsid_x_obi_inf_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/hsid_x_result_wb.sv
// Writes the four-word MSE result record over OBI, one transaction at a time.
// Optional transaction watchdog enabled by defining HSID_X_WB_TIMEOUT_EN.
module hsid_x_result_wb
    import hsid_x_obi_inf_pkg::*;
#(
    parameter int unsigned WORD_WIDTH            = 32,
    parameter int unsigned HSI_LIBRARY_SIZE      = 4095,
    parameter int unsigned TIMEOUT_CYCLES        = 256,
    localparam int unsigned HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [WORD_WIDTH-1:0]            result_addr,
    input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] mse_min_ref,
    input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] mse_max_ref,
    input  logic [WORD_WIDTH-1:0]            mse_min_value,
    input  logic [WORD_WIDTH-1:0]            mse_max_value,
    output obi_req_t                         obi_req_o,
    input  obi_resp_t                        obi_rsp_i,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic                             overrun
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StFinish} state_t;

    state_t                           state_q;
    logic [1:0]                       idx_q;
    logic [WORD_WIDTH-1:0]            base_q;
    logic [HSI_LIBRARY_SIZE_ADDR-1:0] min_ref_q;
    logic [HSI_LIBRARY_SIZE_ADDR-1:0] max_ref_q;
    logic [WORD_WIDTH-1:0]            min_val_q;
    logic [WORD_WIDTH-1:0]            max_val_q;
    obi_req_t                         req_q;
    logic                             busy_q;
    logic                             done_q;
    logic                             overrun_q;
    logic [WORD_WIDTH-1:0]            base_in;

`ifdef HSID_X_WB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q;
    logic             error_q;
`endif

    assign base_in = {result_addr[WORD_WIDTH-1:2], 2'b00};

    function automatic logic [WORD_WIDTH-1:0] word_addr(input logic [WORD_WIDTH-1:0] base,
                                                        input logic [1:0] idx);
        return base + {{(WORD_WIDTH-4){1'b0}}, idx, 2'b00};
    endfunction

    function automatic logic [WORD_WIDTH-1:0] word_data(input logic [1:0] idx);
        logic [WORD_WIDTH-1:0] d;
        d = '0;
        unique case (idx)
            2'd0: d = WORD_WIDTH'(min_ref_q);
            2'd1: d = min_val_q;
            2'd2: d = WORD_WIDTH'(max_ref_q);
            2'd3: d = max_val_q;
        endcase
        return d;
    endfunction

    function automatic obi_req_t make_req(input logic [WORD_WIDTH-1:0] addr,
                                          input logic [WORD_WIDTH-1:0] wdata);
        obi_req_t r;
        r       = '0;
        r.req   = 1'b1;
        r.we    = 1'b1;
        r.be    = 4'hF;
        r.addr  = 32'(addr);
        r.wdata = 32'(wdata);
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            base_q    <= '0;
            min_ref_q <= '0;
            max_ref_q <= '0;
            min_val_q <= '0;
            max_val_q <= '0;
            req_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef HSID_X_WB_TIMEOUT_EN
            cnt_q     <= '0;
            error_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef HSID_X_WB_TIMEOUT_EN
            error_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        base_q    <= base_in;
                        min_ref_q <= mse_min_ref;
                        max_ref_q <= mse_max_ref;
                        min_val_q <= mse_min_value;
                        max_val_q <= mse_max_value;
                        idx_q     <= '0;
                        overrun_q <= 1'b0;
                        busy_q    <= 1'b1;
                        req_q     <= make_req(base_in, WORD_WIDTH'(mse_min_ref));
                        state_q   <= StReq;
`ifdef HSID_X_WB_TIMEOUT_EN
                        cnt_q     <= '0;
`endif
                    end
                end
                StReq: begin
                    if (obi_rsp_i.gnt) begin
                        req_q   <= '0;
                        state_q <= StWait;
`ifdef HSID_X_WB_TIMEOUT_EN
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        req_q   <= '0;
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                        state_q <= StFinish;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
`endif
                    end
                end
                StWait: begin
                    // rvalid only ever closes the single outstanding write
                    if (obi_rsp_i.rvalid) begin
                        idx_q <= idx_q + 2'd1;
`ifdef HSID_X_WB_TIMEOUT_EN
                        cnt_q <= '0;
`endif
                        if (idx_q != 2'd3) begin
                            req_q   <= make_req(word_addr(base_q, idx_q + 2'd1),
                                                word_data(idx_q + 2'd1));
                            state_q <= StReq;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= StFinish;
                        end
`ifdef HSID_X_WB_TIMEOUT_EN
                    end else if (cnt_q == CNT_MAX) begin
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                        state_q <= StFinish;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
`endif
                    end
                end
                StFinish: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
            if (start && state_q != StIdle) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign obi_req_o = req_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;
`ifdef HSID_X_WB_TIMEOUT_EN
    assign error     = error_q;
`else
    assign error     = 1'b0;
`endif

    logic unused_cfg;
    assign unused_cfg = ^{obi_rsp_i.rdata, TIMEOUT_CYCLES};

endmodule
